tag_rx_word_assembler: RTL and testbench

- Receive-side counterpart of the tag memory interface's bit-serial transmit path.
- Takes the decoded downlink bit stream one bit per data_clk-qualified strobe and assembles it MSB-first into 16-bit words.
- Double-buffers each completed word toward the memory interface with a ready/ack handshake.
- Runs the Gen2 CRC-16 over the whole packet and reports packet status when the packet ends.

---
 rtl/tag_rx_pkg.sv | 17 +
 rtl/tag_crc16_serial.sv | 32 +++
 rtl/tag_rx_word_assembler.sv | 139 +++++++++++++
 tb/tb_tag_rx_word_assembler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tag_rx_pkg.sv
// Shared constants and FSM encoding for the tag downlink word assembler
// and its serial CRC-16 engine.
package tag_rx_pkg;

    localparam int          WORD_W      = 16;
    localparam int          MAX_WORDS   = 32;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLOSE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/tag_crc16_serial.sv
// Bit-serial Gen2 CRC-16 engine, one bit per enabled cycle, MSB first.
// Shared with the backscatter CRC generator, hence the parameterised preset.
module tag_crc16_serial
    import tag_rx_pkg::*;
#(
    parameter logic [15:0] POLY   = CRC16_POLY,
    parameter logic [15:0] PRESET = CRC_PRESET
) (
    input  logic        data_clk,
    input  logic        factory_reset,
    input  logic        init,
    input  logic        enable,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic feedback;

    assign feedback = crc_out[15] ^ data_in;

    // init outranks enable so a restart never folds in the bit that came with it.
    always_ff @(posedge data_clk or posedge factory_reset) begin
        if (factory_reset) begin
            crc_out <= PRESET;
        end else if (init) begin
            crc_out <= PRESET;
        end else if (enable) begin
            crc_out <= {crc_out[14:0], 1'b0} ^ (feedback ? POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/tag_rx_word_assembler.sv
// Assembles the decoded downlink bit stream into 16-bit words, hands them
// over through a ready/ack holding register and checks the packet CRC.
module tag_rx_word_assembler
    import tag_rx_pkg::*;
(
    input  logic                data_clk,
    input  logic                factory_reset,
    input  logic                rx_start,
    input  logic                rx_bit,
    input  logic                rx_bit_valid,
    input  logic                rx_end,
    input  logic                word_ack,
    output logic [WORD_W-1:0]   word_data,
    output logic                word_ready,
    output logic [5:0]          word_count,
    output logic                rx_busy,
    output logic                packet_done,
    output logic                crc_ok,
    output logic                frame_error,
    output logic                overflow
);

    rx_state_t          state;
    rx_state_t          state_next;
    logic [WORD_W-1:0]  shift_reg;
    logic [3:0]         bit_cnt;
    logic [15:0]        crc;
    logic               start_pkt;
    logic               take_bit;
    logic               close_pkt;
    logic               word_done;
    logic               word_load;
    logic [WORD_W-1:0]  assembled;

    always_ff @(posedge data_clk or posedge factory_reset) begin
        if (factory_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Restart outranks rx_end, which outranks a data bit in the same cycle.
    always_comb begin
        state_next  = state;
        start_pkt   = 1'b0;
        take_bit    = 1'b0;
        close_pkt   = 1'b0;
        rx_busy     = 1'b0;
        packet_done = 1'b0;
        case (state)
            IDLE: begin
                if (rx_start) begin
                    start_pkt  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                rx_busy = 1'b1;
                if (rx_start) begin
                    start_pkt = 1'b1;
                end else if (rx_end) begin
                    close_pkt  = 1'b1;
                    state_next = CLOSE;
                end else if (rx_bit_valid) begin
                    take_bit = 1'b1;
                end
            end
            CLOSE: begin
                packet_done = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign assembled = {shift_reg[WORD_W-2:0], rx_bit};
    assign word_done = take_bit && (bit_cnt == 4'd15);
    assign word_load = word_done && (!word_ready || word_ack);

    always_ff @(posedge data_clk or posedge factory_reset) begin
        if (factory_reset) begin
            shift_reg   <= '0;
            bit_cnt     <= 4'd0;
            word_count  <= 6'd0;
            crc_ok      <= 1'b0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else if (start_pkt) begin
            shift_reg   <= '0;
            bit_cnt     <= 4'd0;
            word_count  <= 6'd0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else if (take_bit) begin
            shift_reg <= assembled;
            bit_cnt   <= bit_cnt + 4'd1;
            if (word_load && (word_count != 6'(MAX_WORDS))) begin
                word_count <= word_count + 6'd1;
            end
            if (word_done && !word_load) begin
                overflow <= 1'b1;
            end
        end else if (close_pkt) begin
            crc_ok      <= (crc == CRC_RESIDUE);
            frame_error <= (bit_cnt != 4'd0);
            shift_reg   <= '0;
            bit_cnt     <= 4'd0;
        end
    end

    // Holding register lives independently of the FSM so a word survives packet end.
    always_ff @(posedge data_clk or posedge factory_reset) begin
        if (factory_reset) begin
            word_data  <= '0;
            word_ready <= 1'b0;
        end else if (word_load) begin
            word_data  <= assembled;
            word_ready <= 1'b1;
        end else if (word_ack && word_ready) begin
            word_ready <= 1'b0;
        end
    end

    tag_crc16_serial #(
        .POLY   (CRC16_POLY),
        .PRESET (CRC_PRESET)
    ) u_crc (
        .data_clk      (data_clk),
        .factory_reset (factory_reset),
        .init          (start_pkt),
        .enable        (take_bit),
        .data_in       (rx_bit),
        .crc_out       (crc)
    );

endmodule

// File: tb/tb_tag_rx_word_assembler.sv
// Directed bench for tag_rx_word_assembler: good/bad CRC packets, overflow,
// partial words, async reset mid-packet and restart mid-packet.
module tb_tag_rx_word_assembler;

    logic        data_clk = 1'b0;
    logic        factory_reset;
    logic        rx_start;
    logic        rx_bit;
    logic        rx_bit_valid;
    logic        rx_end;
    logic        word_ack;
    logic [15:0] word_data;
    logic        word_ready;
    logic [5:0]  word_count;
    logic        rx_busy;
    logic        packet_done;
    logic        crc_ok;
    logic        frame_error;
    logic        overflow;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] crc_word;

    tag_rx_word_assembler dut (
        .data_clk      (data_clk),
        .factory_reset (factory_reset),
        .rx_start      (rx_start),
        .rx_bit        (rx_bit),
        .rx_bit_valid  (rx_bit_valid),
        .rx_end        (rx_end),
        .word_ack      (word_ack),
        .word_data     (word_data),
        .word_ready    (word_ready),
        .word_count    (word_count),
        .rx_busy       (rx_busy),
        .packet_done   (packet_done),
        .crc_ok        (crc_ok),
        .frame_error   (frame_error),
        .overflow      (overflow)
    );

    always #5 data_clk = ~data_clk;

    function automatic logic [15:0] crcModel(input logic [15:0] seed, input logic [15:0] word);
        logic [15:0] c;
        logic        fb;
        c = seed;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic applyStimulus(input logic start, input logic valid, input logic bit_v,
                                 input logic end_v, input logic ack);
        rx_start     = start;
        rx_bit_valid = valid;
        rx_bit       = bit_v;
        rx_end       = end_v;
        word_ack     = ack;
        @(posedge data_clk);
        #1;
    endtask

    task automatic sendBits(input logic [31:0] value, input int nbits, input logic ack);
        for (int i = nbits - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, value[i], 1'b0, ack);
        end
    endtask

    task automatic checkAllZero(input string prefix);
        checkOutput({prefix, "_word_data"},   word_data,           16'h0000);
        checkOutput({prefix, "_word_ready"},  16'(word_ready),     16'h0);
        checkOutput({prefix, "_word_count"},  16'(word_count),     16'h0);
        checkOutput({prefix, "_rx_busy"},     16'(rx_busy),        16'h0);
        checkOutput({prefix, "_packet_done"}, 16'(packet_done),    16'h0);
        checkOutput({prefix, "_crc_ok"},      16'(crc_ok),         16'h0);
        checkOutput({prefix, "_frame_error"}, 16'(frame_error),    16'h0);
        checkOutput({prefix, "_overflow"},    16'(overflow),       16'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        factory_reset = 1'b1;
        rx_start      = 1'b0;
        rx_bit        = 1'b0;
        rx_bit_valid  = 1'b0;
        rx_end        = 1'b0;
        word_ack      = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge data_clk);
        #1;
        factory_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Good packet: payload 0xA5C3 followed by its complemented CRC.
        crc_word = ~crcModel(16'hFFFF, 16'hA5C3);
        $display("[TB] packet 0xA5C3 with CRC word 0x%0h", crc_word);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p1_busy_after_start", 16'(rx_busy), 16'h1);
        checkOutput("p1_count_after_start", 16'(word_count), 16'h0);
        sendBits(32'h0000_A5C3, 16, 1'b1);
        checkOutput("p1_w1_ready", 16'(word_ready), 16'h1);
        checkOutput("p1_w1_data", word_data, 16'hA5C3);
        checkOutput("p1_w1_count", 16'(word_count), 16'h1);
        applyStimulus(1'b0, 1'b1, crc_word[15], 1'b0, 1'b1);
        checkOutput("p1_w1_acked", 16'(word_ready), 16'h0);
        sendBits({16'h0, crc_word}, 15, 1'b1);
        checkOutput("p1_w2_ready", 16'(word_ready), 16'h1);
        checkOutput("p1_w2_data", word_data, crc_word);
        checkOutput("p1_w2_count", 16'(word_count), 16'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("p1_done", 16'(packet_done), 16'h1);
        checkOutput("p1_crc_ok", 16'(crc_ok), 16'h1);
        checkOutput("p1_count_end", 16'(word_count), 16'h2);
        checkOutput("p1_frame_error", 16'(frame_error), 16'h0);
        checkOutput("p1_busy_close", 16'(rx_busy), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p1_done_cleared", 16'(packet_done), 16'h0);

        // Same packet with payload bit 5 flipped: CRC must fail.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendBits(32'h0000_A5E3, 16, 1'b1);
        checkOutput("p2_w1_data", word_data, 16'hA5E3);
        sendBits({16'h0, crc_word}, 16, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("p2_done", 16'(packet_done), 16'h1);
        checkOutput("p2_crc_ok", 16'(crc_ok), 16'h0);
        checkOutput("p2_count", 16'(word_count), 16'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Three words with no ack: first word is held, later ones overflow.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("p3_ready_before", 16'(word_ready), 16'h0);
        sendBits(32'h0000_1111, 16, 1'b0);
        checkOutput("p3_w1_data", word_data, 16'h1111);
        checkOutput("p3_w1_overflow", 16'(overflow), 16'h0);
        sendBits(32'h0000_2222, 16, 1'b0);
        checkOutput("p3_w2_overflow", 16'(overflow), 16'h1);
        checkOutput("p3_w2_data", word_data, 16'h1111);
        checkOutput("p3_w2_count", 16'(word_count), 16'h1);
        sendBits(32'h0000_3333, 16, 1'b0);
        checkOutput("p3_w3_data", word_data, 16'h1111);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("p3_count_end", 16'(word_count), 16'h1);
        checkOutput("p3_overflow_end", 16'(overflow), 16'h1);
        checkOutput("p3_ready_held", 16'(word_ready), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p3_ready_after_ack", 16'(word_ready), 16'h0);
        checkOutput("p3_overflow_sticky", 16'(overflow), 16'h1);

        // 20 bits then rx_end: partial word gives a frame error.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p4_overflow_cleared", 16'(overflow), 16'h0);
        sendBits(32'h000A_BCDE, 20, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("p4_done", 16'(packet_done), 16'h1);
        checkOutput("p4_frame_error", 16'(frame_error), 16'h1);
        checkOutput("p4_count", 16'(word_count), 16'h1);
        checkOutput("p4_busy", 16'(rx_busy), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("p4_done_one_cycle", 16'(packet_done), 16'h0);
        checkOutput("p4_frame_error_held", 16'(frame_error), 16'h1);

        // Asynchronous reset 9 bits into the second word.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendBits(32'h0000_1234, 16, 1'b1);
        sendBits(32'h0000_01AB, 9, 1'b1);
        rx_bit_valid  = 1'b0;
        factory_reset = 1'b1;
        #2;
        checkAllZero("p5_reset");
        @(posedge data_clk);
        #1;
        factory_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendBits(32'h0000_FFFF, 16, 1'b1);
        checkOutput("p5_data", word_data, 16'hFFFF);
        checkOutput("p5_count", 16'(word_count), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("p5_frame_error", 16'(frame_error), 16'h0);

        // Restart after 7 bits; the restart cycle also carries a bit that must be dropped.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        sendBits(32'h0000_0055, 7, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("p6_busy_restart", 16'(rx_busy), 16'h1);
        checkOutput("p6_count_restart", 16'(word_count), 16'h0);
        sendBits(32'h0000_0F0F, 16, 1'b1);
        checkOutput("p6_data", word_data, 16'h0F0F);
        checkOutput("p6_count", 16'(word_count), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("p6_done", 16'(packet_done), 16'h1);
        checkOutput("p6_frame_error", 16'(frame_error), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
